// File: rtl/ni_injector_pkg.sv
// ni_injector_pkg: flit, state and width definitions shared by the NI injection stage.
package ni_injector_pkg;
    localparam int DATA_W   = 32;
    localparam int LEN_W    = 4;
    localparam int PKT_ID_W = 8;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 16;

    typedef logic [ADDR_W-1:0] PORT_ADDR_t;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} FLIT_TYPE_t;

    typedef struct packed {
        FLIT_TYPE_t        flit_type;
        logic [DATA_W-1:0] payload;
    } FLIT_t;

    typedef enum logic [1:0] {NI_IDLE, NI_HEAD, NI_DATA, NI_DONE} NI_STATE_t;

    function automatic logic [DATA_W-1:0] head_payload(
        input logic [PKT_ID_W-1:0] id,
        input logic [LEN_W-1:0]    len,
        input PORT_ADDR_t          dst
    );
        return DATA_W'({id, len, dst});
    endfunction
endpackage

// File: rtl/ni_injector_if.sv
// ni_injector_if: core-side descriptor/word handshakes and router-side flit link.
interface ni_injector_if;
    import ni_injector_pkg::*;
    logic              i_desc_valid;
    PORT_ADDR_t        i_desc_dst;
    logic [LEN_W-1:0]  i_desc_len;
    logic              o_desc_ready;
    logic              i_word_valid;
    logic [DATA_W-1:0] i_word_data;
    logic              o_word_ready;
    logic              i_on_off;
    logic              o_upstream_req;
    FLIT_t             o_flit;
    logic              o_busy;
    logic [CNT_W-1:0]  o_pkt_sent_cnt;

    modport master (
        output i_desc_valid, i_desc_dst, i_desc_len, i_word_valid, i_word_data, i_on_off,
        input  o_desc_ready, o_word_ready, o_upstream_req, o_flit, o_busy, o_pkt_sent_cnt
    );

    modport slave (
        input  i_desc_valid, i_desc_dst, i_desc_len, i_word_valid, i_word_data, i_on_off,
        output o_desc_ready, o_word_ready, o_upstream_req, o_flit, o_busy, o_pkt_sent_cnt
    );
endinterface

// File: rtl/ni_word_fifo.sv
// ni_word_fifo: circular word buffer; pointers carry an extra wrap bit to tell full from empty.
module ni_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/ni_injector.sv
// ni_injector: segments core descriptors and buffered words into HEAD/BODY/TAIL flits
// and injects them into the router under on/off flow control.
module ni_injector
    import ni_injector_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          reset_n,
    ni_injector_if.slave ni
);
    NI_STATE_t         state, state_d;
    PORT_ADDR_t        dst_q;
    logic [LEN_W-1:0]  len_q, remaining;
    logic [PKT_ID_W-1:0] pkt_id;
    logic [CNT_W-1:0]  sent_cnt;
    logic              req_q, issue, push, pop, full, empty;
    FLIT_t             flit_q, flit_d;
    logic [DATA_W-1:0] head_word;

    assign push = ni.i_word_valid && ni.o_word_ready;
    assign pop  = issue && state == NI_DATA;

    ni_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .din(ni.i_word_data),
        .pop(pop),
        .dout(head_word),
        .full(full),
        .empty(empty)
    );

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        flit_d  = flit_q;
        case (state)
            NI_IDLE: state_d = ni.i_desc_valid ? NI_HEAD : NI_IDLE;
            NI_HEAD: begin
                issue  = ni.i_on_off;
                flit_d = '{flit_type: (len_q == '0) ? HEADTAIL : HEAD,
                           payload: head_payload(pkt_id, len_q, dst_q)};
                if (issue) state_d = (len_q == '0) ? NI_DONE : NI_DATA;
            end
            NI_DATA: begin
                // an empty FIFO holds the packet in place rather than emitting a bubble
                issue  = ni.i_on_off && !empty;
                flit_d = '{flit_type: (remaining == LEN_W'(1)) ? TAIL : BODY, payload: head_word};
                if (issue && remaining == LEN_W'(1)) state_d = NI_DONE;
            end
            default: state_d = NI_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= NI_IDLE;
            dst_q     <= '0;
            len_q     <= '0;
            remaining <= '0;
            pkt_id    <= '0;
            sent_cnt  <= '0;
            req_q     <= 1'b0;
            flit_q    <= '0;
        end else begin
            state <= state_d;
            req_q <= issue;
            if (issue) flit_q <= flit_d;
            if (state == NI_IDLE && ni.i_desc_valid) begin
                dst_q <= ni.i_desc_dst;
                len_q <= ni.i_desc_len;
            end
            if (issue) remaining <= (state == NI_HEAD) ? len_q : remaining - 1'b1;
            if (state == NI_DONE) begin
                sent_cnt <= sent_cnt + 1'b1;
                pkt_id   <= pkt_id + 1'b1;
            end
        end
    end

    assign ni.o_upstream_req = req_q;
    assign ni.o_flit         = flit_q;
    assign ni.o_busy         = state != NI_IDLE;
    assign ni.o_desc_ready   = reset_n && state == NI_IDLE;
    assign ni.o_word_ready   = reset_n && !full;
    assign ni.o_pkt_sent_cnt = sent_cnt;
endmodule

// File: tb/tb_ni_injector.sv
// tb_ni_injector: directed packets against a queue of expected flits drained by a monitor thread.
module tb_ni_injector;
    import ni_injector_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    ni_injector_if nif();

    ni_injector dut (.clk(clk), .reset_n(reset_n), .ni(nif));

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    logic [33:0] exp_q[$];
    logic [PKT_ID_W-1:0] exp_id = '0;
    logic prev_on_off = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [33:0] mk(input FLIT_TYPE_t t, input logic [31:0] p);
        return {t, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        logic acc;
        int n = 0;
        nif.i_word_valid = 1'b1;
        nif.i_word_data  = d;
        do begin
            acc = nif.o_word_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        nif.i_word_valid = 1'b0;
        if (!acc) check("word_accept_timeout", 64'(acc), 64'(1));
    endtask

    // Queues the HEAD plus data flits (words base+1..base+len) before handing the descriptor over.
    task automatic send_desc(input logic [3:0] dst, input logic [3:0] len, input logic [31:0] base);
        logic acc;
        int n = 0;
        exp_q.push_back(mk((len == 4'd0) ? HEADTAIL : HEAD, {16'b0, exp_id, len, dst}));
        for (int i = 1; i <= int'(len); i++)
            exp_q.push_back(mk((i == int'(len)) ? TAIL : BODY, base + 32'(i)));
        exp_id++;
        nif.i_desc_valid = 1'b1;
        nif.i_desc_dst   = dst;
        nif.i_desc_len   = len;
        do begin
            acc = nif.o_desc_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        nif.i_desc_valid = 1'b0;
        if (!acc) check("desc_accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while ((nif.o_busy || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("idle_timeout", 64'(n), 64'(0));
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (nif.o_upstream_req) begin
                check("on_off_at_issue", 64'(prev_on_off), 64'(1));
                check("flit_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) check("flit", 64'(nif.o_flit), 64'(exp_q.pop_front()));
            end
            prev_on_off = nif.i_on_off;
        end
    endtask

    initial begin
        int n;
        logic acc;
        nif.i_desc_valid = 1'b0;
        nif.i_desc_dst   = '0;
        nif.i_desc_len   = '0;
        nif.i_word_valid = 1'b0;
        nif.i_word_data  = '0;
        nif.i_on_off     = 1'b1;
        fork
            monitor();
        join_none
        #3;
        check("rst_desc_ready", 64'(nif.o_desc_ready), 64'(0));
        check("rst_word_ready", 64'(nif.o_word_ready), 64'(0));
        check("rst_req", 64'(nif.o_upstream_req), 64'(0));
        check("rst_busy", 64'(nif.o_busy), 64'(0));
        check("rst_cnt", 64'(nif.o_pkt_sent_cnt), 64'(0));
        check("rst_flit", 64'(nif.o_flit), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_desc_ready", 64'(nif.o_desc_ready), 64'(1));
        check("idle_word_ready", 64'(nif.o_word_ready), 64'(1));

        // packet of three preloaded words, full rate
        for (int i = 1; i <= 3; i++) push_word(32'hA0 + 32'(i));
        send_desc(4'd2, 4'd3, 32'hA0);
        wait_idle(n);
        check("len3_cycles", 64'(n), 64'(5));
        check("cnt_after_len3", 64'(nif.o_pkt_sent_cnt), 64'(1));

        // zero-length packet: single HEADTAIL
        send_desc(4'd5, 4'd0, 32'h0);
        wait_idle(n);
        check("len0_cycles", 64'(n), 64'(2));
        check("cnt_after_len0", 64'(nif.o_pkt_sent_cnt), 64'(2));

        // on_off dropped for 5 cycles after the second BODY
        for (int i = 1; i <= 4; i++) push_word(32'hB0 + 32'(i));
        send_desc(4'd7, 4'd4, 32'hB0);
        repeat (3) tick();
        nif.i_on_off = 1'b0;
        repeat (5) tick();
        check("busy_while_off", 64'(nif.o_busy), 64'(1));
        nif.i_on_off = 1'b1;
        wait_idle(n);
        check("cnt_after_onoff", 64'(nif.o_pkt_sent_cnt), 64'(3));

        // words trickle in one per four cycles after the descriptor
        send_desc(4'd1, 4'd3, 32'hD0);
        for (int i = 1; i <= 3; i++) begin
            push_word(32'hD0 + 32'(i));
            repeat (3) tick();
        end
        wait_idle(n);
        check("cnt_after_trickle", 64'(nif.o_pkt_sent_cnt), 64'(4));

        // fill the FIFO with no descriptor; fifth word must wait for space
        for (int i = 1; i <= 4; i++) push_word(32'hC0 + 32'(i));
        nif.i_word_valid = 1'b1;
        nif.i_word_data  = 32'hC5;
        tick();
        check("full_word_ready", 64'(nif.o_word_ready), 64'(0));
        send_desc(4'd3, 4'd4, 32'hC0);
        n = 0;
        do begin
            acc = nif.o_word_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        nif.i_word_valid = 1'b0;
        check("fifth_word_accepted", 64'(acc), 64'(1));
        wait_idle(n);
        send_desc(4'd3, 4'd1, 32'hC4);
        wait_idle(n);
        check("cnt_after_full", 64'(nif.o_pkt_sent_cnt), 64'(6));

        // asynchronous reset while words remain buffered mid-packet
        for (int i = 1; i <= 3; i++) push_word(32'hE0 + 32'(i));
        send_desc(4'd4, 4'd3, 32'hE0);
        tick();
        tick();
        nif.i_on_off = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_req", 64'(nif.o_upstream_req), 64'(0));
        check("async_busy", 64'(nif.o_busy), 64'(0));
        check("async_desc_ready", 64'(nif.o_desc_ready), 64'(0));
        check("async_word_ready", 64'(nif.o_word_ready), 64'(0));
        check("async_cnt", 64'(nif.o_pkt_sent_cnt), 64'(0));
        check("async_flit", 64'(nif.o_flit), 64'(0));
        exp_q.delete();
        exp_id = '0;
        tick();
        reset_n = 1'b1;
        nif.i_on_off = 1'b1;
        tick();
        check("post_rst_desc_ready", 64'(nif.o_desc_ready), 64'(1));
        check("post_rst_word_ready", 64'(nif.o_word_ready), 64'(1));
        check("post_rst_busy", 64'(nif.o_busy), 64'(0));
        push_word(32'hF1);
        send_desc(4'd6, 4'd1, 32'hF0);
        wait_idle(n);
        check("cnt_after_reset", 64'(nif.o_pkt_sent_cnt), 64'(1));
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
